// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: default widths, FSM state
// encodings and the latched operation code.
package mem_responder_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/mem_responder_if.sv
// MAR/MDR-side memory bus: the control sequence (master) raises Read/Write,
// the responder (slave) answers with Mdatain, MemRdy, Busy and Err.
interface mem_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic [ADDR_W-1:0] Address;
    logic              Read;
    logic              Write;
    logic [DATA_W-1:0] Mdataout;
    logic [DATA_W-1:0] Mdatain;
    logic              MemRdy;
    logic              Busy;
    logic              Err;

    modport master (
        output Address, Read, Write, Mdataout,
        input  Mdatain, MemRdy, Busy, Err
    );

    modport slave (
        input  Address, Read, Write, Mdataout,
        output Mdatain, MemRdy, Busy, Err
    );
endinterface

// File: rtl/mem_responder_array.sv
// Single-port synchronous RAM behind the responder. The read register only
// loads when re_i is set, so it doubles as the held Mdatain value.
module mem_array #(
    parameter int    DATA_W    = 32,
    parameter int    ADDR_W    = 9,
    parameter int    DEPTH     = 512,
    parameter string INIT_FILE = ""
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] dout_q;

    // Power-up image: all zeros.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
    end

    // Array write port; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= din_i;
    end

    // Read data register, cleared by reset, updated only on a read access.
    always_ff @(posedge clk_i) begin
        if (rst_i)     dout_q <= '0;
        else if (re_i) dout_q <= mem_q[addr_i];
    end

    assign dout_o = dout_q;
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: edge-detects Read/Write, latches the request, waits
// WAIT_STATES cycles, performs one array access and pulses MemRdy.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int    DATA_W      = DATA_W_DEF,
    parameter int    ADDR_W      = ADDR_W_DEF,
    parameter int    DEPTH       = 512,
    parameter int    WAIT_STATES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic           Clock,
    input  logic           Clear,
    mem_responder_if.slave bus
);
    localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

    logic              rd_hist_q, wr_hist_q;
    logic              rd_rise, wr_rise;
    logic              req_q, req_err_q;
    op_e               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              busy_q, rdy_q, err_q;
    logic              ram_we, ram_re;
    logic [DATA_W-1:0] ram_dout;

    assign rd_rise = bus.Read  & ~rd_hist_q;
    assign wr_rise = bus.Write & ~wr_hist_q;

    // Request history follows the input levels, also while Clear is held, so a
    // level held through reset is not mistaken for a new request afterwards.
    always_ff @(posedge Clock) begin
        rd_hist_q <= bus.Read;
        wr_hist_q <= bus.Write;
    end

    // Accept stage: one rise taken while idle; address/data/op latched here so
    // later bus changes cannot affect the access. Collisions become reads.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            req_q     <= 1'b0;
            req_err_q <= 1'b0;
        end else if (state_q == ST_IDLE && !req_q && (rd_rise || wr_rise)) begin
            req_q     <= 1'b1;
            req_err_q <= rd_rise & wr_rise;
            op_q      <= rd_rise ? OP_RD : OP_WR;
            addr_q    <= bus.Address;
            data_q    <= bus.Mdataout;
        end else begin
            req_q     <= 1'b0;
        end
    end

    // Access sequencer with registered Busy/MemRdy/Err outputs.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_q) begin
                        busy_q  <= 1'b1;
                        err_q   <= req_err_q;
                        cnt_q   <= WS_CNT;
                        state_q <= (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    rdy_q   <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ram_we = (state_q == ST_ACCESS) && (op_q == OP_WR);
    assign ram_re = (state_q == ST_ACCESS) && (op_q == OP_RD);

    mem_array #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .INIT_FILE(INIT_FILE)
    ) u_array (
        .clk_i (Clock),
        .rst_i (Clear),
        .we_i  (ram_we),
        .re_i  (ram_re),
        .addr_i(addr_q),
        .din_i (data_q),
        .dout_o(ram_dout)
    );

    assign bus.Mdatain = ram_dout;
    assign bus.MemRdy  = rdy_q;
    assign bus.Busy    = busy_q;
    assign bus.Err     = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (2, 0 and 5 wait states), directed
// operations with a reference memory and a queue of expected read data.
module tb_mem_responder;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    mem_responder_if #(.DATA_W(32), .ADDR_W(9)) if_m ();
    mem_responder_if #(.DATA_W(32), .ADDR_W(9)) if_0 ();
    mem_responder_if #(.DATA_W(32), .ADDR_W(9)) if_5 ();

    mem_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_STATES(2), .INIT_FILE(""))
        u_dut (.Clock(clk), .Clear(clr), .bus(if_m));
    mem_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_STATES(0), .INIT_FILE(""))
        u_ws0 (.Clock(clk), .Clear(clr), .bus(if_0));
    mem_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_STATES(5), .INIT_FILE(""))
        u_ws5 (.Clock(clk), .Clear(clr), .bus(if_5));

    typedef struct packed {
        logic [31:0] mdatain;
        logic        rdy;
        logic        busy;
        logic        err;
    } obs_t;

    int          total = 0;
    int          passed = 0;
    logic [31:0] model [3][512];
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int ws_of(input int sel);
        case (sel)
            1:       return 0;
            2:       return 5;
            default: return 2;
        endcase
    endfunction

    function automatic obs_t sample(input int sel);
        obs_t o;
        case (sel)
            1:       o = '{if_0.Mdatain, if_0.MemRdy, if_0.Busy, if_0.Err};
            2:       o = '{if_5.Mdatain, if_5.MemRdy, if_5.Busy, if_5.Err};
            default: o = '{if_m.Mdatain, if_m.MemRdy, if_m.Busy, if_m.Err};
        endcase
        return o;
    endfunction

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [8:0] a, input logic [31:0] d);
        case (sel)
            1:       begin if_0.Read = rd; if_0.Write = wr; if_0.Address = a; if_0.Mdataout = d; end
            2:       begin if_5.Read = rd; if_5.Write = wr; if_5.Address = a; if_5.Mdataout = d; end
            default: begin if_m.Read = rd; if_m.Write = wr; if_m.Address = a; if_m.Mdataout = d; end
        endcase
    endtask

    // One operation: timing, pulse widths, Err and read data against the model.
    // glitch: drop and re-raise Read (and move Address/Mdataout) while waiting.
    // hold: leave the request level high at the end.
    task automatic do_op(input int sel, input logic rd, input logic wr,
                         input logic [8:0] a, input logic [31:0] d,
                         input bit glitch, input bit hold, input string tag);
        int          ws = ws_of(sel);
        int          rdy_cnt = 0, rdy_at = 0, busy_cnt = 0, err_cnt = 0;
        logic [31:0] got_d = '0;
        logic [31:0] exp_d;
        obs_t        o;
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, a, d);
        @(negedge clk);
        drive(sel, rd, wr, a, d);
        if (rd) exp_q.push_back(model[sel][a]);
        else if (wr) model[sel][a] = d;
        for (int n = 1; n <= ws + 8; n++) begin
            @(posedge clk);
            @(negedge clk);
            o = sample(sel);
            if (o.busy) busy_cnt++;
            if (o.err) err_cnt++;
            if (o.rdy) begin
                rdy_cnt++;
                if (rdy_cnt == 1) begin
                    rdy_at = n;
                    got_d  = o.mdatain;
                end
            end
            if (glitch && n == 1) drive(sel, 1'b0, wr, a + 9'd1, ~d);
            if (glitch && n == 2) drive(sel, 1'b1, wr, a + 9'd1, ~d);
        end
        check({tag, "/rdy_count"}, rdy_cnt, 1);
        check({tag, "/rdy_latency"}, rdy_at, ws + 3);
        check({tag, "/busy_width"}, busy_cnt, ws + 2);
        check({tag, "/err_count"}, err_cnt, (rd && wr) ? 1 : 0);
        if (rd) begin
            if (exp_q.size() == 0) begin
                check({tag, "/scoreboard_empty"}, 1, 0);
            end else begin
                exp_d = exp_q.pop_front();
                check({tag, "/rdata_at_rdy"}, got_d, exp_d);
                o = sample(sel);
                check({tag, "/rdata_held"}, o.mdatain, exp_d);
            end
        end
        if (!hold) drive(sel, 1'b0, 1'b0, a, d);
    endtask

    initial begin
        obs_t o;
        int   rdy_cnt, busy_cnt;
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 512; i++) model[s][i] = '0;
        clr = 1'b1;
        drive(0, 1'b1, 1'b0, 9'h000, 32'h0);
        drive(1, 1'b0, 1'b0, 9'h000, 32'h0);
        drive(2, 1'b0, 1'b0, 9'h000, 32'h0);

        // Reset with Read held high: outputs clear, no access after release.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        o = sample(0);
        check("reset/mdatain", o.mdatain, 32'h0);
        check("reset/memrdy", o.rdy, 0);
        check("reset/busy", o.busy, 0);
        check("reset/err", o.err, 0);
        clr = 1'b0;
        rdy_cnt = 0;
        busy_cnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            @(negedge clk);
            o = sample(0);
            if (o.rdy) rdy_cnt++;
            if (o.busy) busy_cnt++;
        end
        check("reset/held_read_rdy", rdy_cnt, 0);
        check("reset/held_read_busy", busy_cnt, 0);
        drive(0, 1'b0, 1'b0, 9'h000, 32'h0);

        // Write then read back at 2 wait states.
        do_op(0, 1'b0, 1'b1, 9'h022, 32'h4A920000, 1'b0, 1'b0, "wr022");
        do_op(0, 1'b1, 1'b0, 9'h022, 32'h0, 1'b0, 1'b0, "rd022");

        // Wait-state sweep on the 0 and 5 wait-state instances.
        do_op(1, 1'b0, 1'b1, 9'h010, 32'h12345678, 1'b0, 1'b0, "ws0_wr");
        do_op(1, 1'b1, 1'b0, 9'h010, 32'h0, 1'b0, 1'b0, "ws0_rd");
        do_op(2, 1'b0, 1'b1, 9'h1FF, 32'hDEADBEEF, 1'b0, 1'b0, "ws5_wr");
        do_op(2, 1'b1, 1'b0, 9'h1FF, 32'h0, 1'b0, 1'b0, "ws5_rd");

        // Collision: read+write together at 024, plus a second Read rise mid-wait.
        do_op(0, 1'b1, 1'b1, 9'h024, 32'hFFFF0000, 1'b1, 1'b0, "collide");
        do_op(0, 1'b1, 1'b0, 9'h024, 32'h0, 1'b0, 1'b0, "rd024");

        // Abort a write with Clear while waiting.
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 9'h027, 32'h00000007);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        o = sample(0);
        check("abort/busy_before", o.busy, 1);
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        o = sample(0);
        check("abort/busy_after", o.busy, 0);
        drive(0, 1'b0, 1'b0, 9'h027, 32'h0);
        rdy_cnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            @(negedge clk);
            o = sample(0);
            if (o.rdy) rdy_cnt++;
        end
        check("abort/no_rdy", rdy_cnt, 0);
        do_op(0, 1'b1, 1'b0, 9'h027, 32'h0, 1'b0, 1'b0, "rd027");

        // Read held across DONE gives one access; drop and raise gives another.
        do_op(0, 1'b1, 1'b0, 9'h022, 32'h0, 1'b0, 1'b1, "hold");
        do_op(0, 1'b1, 1'b0, 9'h022, 32'h0, 1'b0, 1'b0, "again");

        check("scoreboard/drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
